// File: rtl/dsp_share_arbiter.sv
// Shares one DSP48E1 slice among NREQ requesters: round-robin grant with burst lock,
// X/Y mux legality screening, and ID-tagged result return. Macro DSP_ARB_STATS_EN adds counters.
module dsp_share_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned LAT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      lock,
  input  logic [NREQ*7-1:0]    opmode_in,
  input  logic [NREQ*4-1:0]    alumode_in,
  output logic [NREQ-1:0]      gnt,
  output logic                 err,
  output logic [IDW-1:0]       err_id,
  output logic [6:0]           dsp_opmode,
  output logic [3:0]           dsp_alumode,
  output logic                 dsp_valid,
  output logic [IDW-1:0]       dsp_id,
  input  logic [47:0]          p_in,
  output logic                 res_valid,
  output logic [IDW-1:0]       res_id,
  output logic [47:0]          res_p
`ifdef DSP_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]   grant_cnt,
  output logic [15:0]          reject_cnt
`endif
);

  localparam int unsigned OPW = 7;
  localparam int unsigned ALW = 4;
  localparam int unsigned PW  = 48;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] rr_q, rr_d;

  logic           acc;
  logic           illegal;
  logic [IDW-1:0] acc_id;
  logic [IDW-1:0] rr_next;
  logic [OPW-1:0] sel_op;
  logic [ALW-1:0] sel_alu;
  int             cand;

  logic [OPW-1:0] op_a  [NREQ];
  logic [ALW-1:0] alu_a [NREQ];

  logic           err_q;
  logic [IDW-1:0] err_id_q;
  logic [OPW-1:0] op_q;
  logic [ALW-1:0] alu_q;
  logic           dv_q;
  logic [IDW-1:0] id_q;
  logic           tag_v_q  [LAT];
  logic [IDW-1:0] tag_id_q [LAT];
  logic           res_v_q;
  logic [IDW-1:0] res_id_q;
  logic [PW-1:0]  res_p_q;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_a[g]  = opmode_in[g*OPW +: OPW];
    assign alu_a[g] = alumode_in[g*ALW +: ALW];
  end

  // Grant selection, legality screen and arbitration state update
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    gnt     = '0;
    acc     = 1'b0;
    acc_id  = '0;
    cand    = 0;
    if (state_q == ST_LOCKED) begin
      if (req[owner_q]) begin
        acc    = 1'b1;
        acc_id = owner_q;
      end
    end else begin
      for (int k = 0; k < int'(NREQ); k++) begin
        cand = int'(rr_q) + k;
        if (cand >= int'(NREQ)) cand = cand - int'(NREQ);
        if (!acc && req[IDW'(cand)]) begin
          acc    = 1'b1;
          acc_id = IDW'(cand);
        end
      end
    end
    if (rst) acc = 1'b0;
    if (acc) gnt[acc_id] = 1'b1;

    sel_op  = op_a[acc_id];
    sel_alu = alu_a[acc_id];
    // Both X and Y must select M, or neither may
    illegal = (sel_op[1:0] == 2'b01) ^ (sel_op[3:2] == 2'b01);
    rr_next = (acc_id == IDW'(NREQ - 1)) ? '0 : acc_id + IDW'(1);

    if (acc && !illegal) begin
      if (state_q == ST_IDLE) begin
        rr_d = rr_next;
        if (lock[acc_id]) begin
          state_d = ST_LOCKED;
          owner_d = acc_id;
        end
      end else if (!lock[acc_id]) begin
        state_d = ST_IDLE;
        rr_d    = rr_next;
      end
    end else if (acc && state_q == ST_IDLE) begin
      rr_d = rr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_q     <= '0;
      err_q    <= 1'b0;
      err_id_q <= '0;
      op_q     <= '0;
      alu_q    <= '0;
      dv_q     <= 1'b0;
      id_q     <= '0;
      for (int k = 0; k < int'(LAT); k++) begin
        tag_v_q[k]  <= 1'b0;
        tag_id_q[k] <= '0;
      end
      res_v_q  <= 1'b0;
      res_id_q <= '0;
      res_p_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      err_q   <= acc && illegal;
      if (acc && illegal) err_id_q <= acc_id;
      dv_q    <= acc && !illegal;
      if (acc && !illegal) begin
        op_q  <= sel_op;
        alu_q <= sel_alu;
        id_q  <= acc_id;
      end
      // Tag pipeline mirrors the slice latency so each P meets its owner
      tag_v_q[0]  <= dv_q;
      tag_id_q[0] <= id_q;
      for (int k = 1; k < int'(LAT); k++) begin
        tag_v_q[k]  <= tag_v_q[k-1];
        tag_id_q[k] <= tag_id_q[k-1];
      end
      res_v_q <= tag_v_q[LAT-1];
      if (tag_v_q[LAT-1]) begin
        res_id_q <= tag_id_q[LAT-1];
        res_p_q  <= p_in;
      end
    end
  end

  assign err         = err_q;
  assign err_id      = err_id_q;
  assign dsp_opmode  = op_q;
  assign dsp_alumode = alu_q;
  assign dsp_valid   = dv_q;
  assign dsp_id      = id_q;
  assign res_valid   = res_v_q;
  assign res_id      = res_id_q;
  assign res_p       = res_p_q;

`ifdef DSP_ARB_STATS_EN
  logic [15:0] gcnt_q [NREQ];
  logic [15:0] rej_q;

  // Saturating legal-grant and reject counters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(NREQ); k++) gcnt_q[k] <= '0;
      rej_q <= '0;
    end else begin
      if (acc && !illegal && gcnt_q[acc_id] != 16'hFFFF)
        gcnt_q[acc_id] <= gcnt_q[acc_id] + 16'd1;
      if (err_q && rej_q != 16'hFFFF) rej_q <= rej_q + 16'd1;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    assign grant_cnt[g*16 +: 16] = gcnt_q[g];
  end
  assign reject_cnt = rej_q;
`endif

endmodule

// File: tb/tb_dsp_share_arbiter.sv
// Randomized bench for dsp_share_arbiter against a cycle-level reference model.
module tb_dsp_share_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int LAT  = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      lock;
  logic [NREQ*7-1:0]    opmode_in;
  logic [NREQ*4-1:0]    alumode_in;
  logic [NREQ-1:0]      gnt;
  logic                 err;
  logic [IDW-1:0]       err_id;
  logic [6:0]           dsp_opmode;
  logic [3:0]           dsp_alumode;
  logic                 dsp_valid;
  logic [IDW-1:0]       dsp_id;
  logic [47:0]          p_in;
  logic                 res_valid;
  logic [IDW-1:0]       res_id;
  logic [47:0]          res_p;
`ifdef DSP_ARB_STATS_EN
  logic [NREQ*16-1:0]   grant_cnt;
  logic [15:0]          reject_cnt;
`endif

  dsp_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock),
    .opmode_in(opmode_in), .alumode_in(alumode_in), .gnt(gnt),
    .err(err), .err_id(err_id), .dsp_opmode(dsp_opmode), .dsp_alumode(dsp_alumode),
    .dsp_valid(dsp_valid), .dsp_id(dsp_id), .p_in(p_in),
    .res_valid(res_valid), .res_id(res_id), .res_p(res_p)
`ifdef DSP_ARB_STATS_EN
    , .grant_cnt(grant_cnt), .reject_cnt(reject_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int due; int id; } exp_t;

  int n_checks = 0;
  int n_errors = 0;

  // stimulus state: one held request per requester
  bit          pend [NREQ];
  logic [6:0]  op_v [NREQ];
  logic [3:0]  alu_v [NREQ];
  bit          lock_v [NREQ];
  bit          rst_v;
  bit          chk_en;
  bit          p_fix_en;
  logic [47:0] p_fix;

  // reference model
  int          cyc;
  int          m_rr;
  bit          m_locked;
  int          m_owner;
  bit          m_was_rst;
  bit          m_last_acc;
  int          m_last_id;
  bit          e_err;
  int          e_err_id;
  bit          e_dv;
  logic [6:0]  e_op;
  logic [3:0]  e_alu;
  int          e_id;
  exp_t        exp_q [$];
  logic [47:0] p_hist [0:8191];
`ifdef DSP_ARB_STATS_EN
  int          m_gcnt [NREQ];
  int          m_rej;
`endif

  // observed values of the latest cycle
  logic [NREQ-1:0] obs_gnt;
  logic            obs_dv, obs_err, obs_rv;
  logic [6:0]      obs_op;
  logic [IDW-1:0]  obs_did, obs_eid, obs_rid;
  logic [47:0]     obs_rp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_locked = 0; m_owner = 0;
    e_err = 0; e_err_id = 0; e_dv = 0; e_op = '0; e_alu = '0; e_id = 0;
    exp_q.delete();
`ifdef DSP_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) m_gcnt[i] = 0;
    m_rej = 0;
`endif
  endtask

  // One clock cycle: drive, check against the model, advance the model
  task automatic step(input logic [47:0] p_v);
    bit              acc;
    int              aid;
    bit              bad;
    bit              due;
    logic [6:0]      op;
    logic [NREQ-1:0] eg;
    @(negedge clk);
    rst = rst_v;
    for (int i = 0; i < NREQ; i++) begin
      req[i]             = pend[i];
      lock[i]            = lock_v[i];
      opmode_in[i*7 +: 7] = op_v[i];
      alumode_in[i*4 +: 4] = alu_v[i];
    end
    p_in = p_v;
    p_hist[cyc] = p_v;
    #1;
    obs_gnt = gnt; obs_dv = dsp_valid; obs_op = dsp_opmode; obs_did = dsp_id;
    obs_err = err; obs_eid = err_id; obs_rv = res_valid; obs_rid = res_id; obs_rp = res_p;

    acc = 0; aid = 0;
    if (!rst_v) begin
      if (m_locked) begin
        if (pend[m_owner]) begin acc = 1; aid = m_owner; end
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          int i;
          i = (m_rr + k) % NREQ;
          if (!acc && pend[i]) begin acc = 1; aid = i; end
        end
      end
    end
    eg = '0;
    if (acc) eg[aid] = 1'b1;

    due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    if (chk_en) begin
      chk("gnt", gnt, eg);
      chk("dsp_valid", dsp_valid, e_dv);
      if (e_dv) chk("dsp_id", dsp_id, e_id);
      chk("dsp_opmode", dsp_opmode, e_op);
      chk("dsp_alumode", dsp_alumode, e_alu);
      chk("err", err, e_err);
      if (e_err) chk("err_id", err_id, e_err_id);
      chk("res_valid", res_valid, due);
      if (due) begin
        chk("res_id", res_id, exp_q[0].id);
        chk("res_p", res_p, p_hist[cyc-1]);
      end
      if (m_was_rst) begin
        chk("rst_dsp_id", dsp_id, 0);
        chk("rst_err_id", err_id, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_p", res_p, 0);
      end
    end
    if (due) void'(exp_q.pop_front());

    e_err = 0; e_dv = 0;
    if (acc) begin
      op  = op_v[aid];
      bad = (op[1:0] == 2'b01) != (op[3:2] == 2'b01);
      if (bad) begin
        e_err = 1; e_err_id = aid;
        if (!m_locked) m_rr = (aid + 1) % NREQ;
`ifdef DSP_ARB_STATS_EN
        m_rej++;
`endif
      end else begin
        e_dv = 1; e_op = op; e_alu = alu_v[aid]; e_id = aid;
        exp_q.push_back('{cyc + LAT + 2, aid});
`ifdef DSP_ARB_STATS_EN
        m_gcnt[aid]++;
`endif
        if (!m_locked) begin
          m_rr = (aid + 1) % NREQ;
          if (lock_v[aid]) begin m_locked = 1; m_owner = aid; end
        end else if (!lock_v[aid]) begin
          m_locked = 0;
          m_rr = (aid + 1) % NREQ;
        end
      end
    end
    if (rst_v) model_reset();
    m_was_rst  = rst_v;
    m_last_acc = acc;
    m_last_id  = aid;
    cyc++;
  endtask

  task automatic cyc_run(input int n, input bit rnd);
    logic [6:0] op;
    for (int s = 0; s < n; s++) begin
      if (rnd) begin
        rst_v = ($urandom_range(399, 0) == 0);
        for (int i = 0; i < NREQ; i++) begin
          if (!pend[i] && $urandom_range(1, 0) == 1) begin
            op = 7'($urandom);
            if ($urandom_range(3, 0) != 0 && ((op[1:0] == 2'b01) != (op[3:2] == 2'b01)))
              op[3:2] = (op[1:0] == 2'b01) ? 2'b01 : 2'b10;
            pend[i]   = 1;
            op_v[i]   = op;
            alu_v[i]  = 4'($urandom);
            lock_v[i] = ($urandom_range(5, 0) == 0);
          end
        end
      end
      step(p_fix_en ? p_fix : {16'($urandom), 32'($urandom)});
      if (m_last_acc) pend[m_last_id] = 0;
    end
  endtask

  task automatic do_reset();
    rst_v = 1;
    cyc_run(1, 0);
    rst_v = 0;
  endtask

  int n_rv;

  initial begin
    rst = 1; req = '0; lock = '0; opmode_in = '0; alumode_in = '0; p_in = '0;
    cyc = 0; chk_en = 0; p_fix_en = 0; p_fix = '0; m_was_rst = 0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 0; op_v[i] = '0; alu_v[i] = '0; lock_v[i] = 0;
    end
    model_reset();
    rst_v = 1;
    cyc_run(2, 0);
    rst_v = 0;
    chk_en = 1;

    // single legal op from requester 0, result tracked through the slice latency
    op_v[0] = 7'b0110101; alu_v[0] = 4'h0; pend[0] = 1;
    p_fix_en = 1; p_fix = 48'h123;
    cyc_run(1, 0);
    chk("t1_gnt", obs_gnt, 4'b0001);
    cyc_run(1, 0);
    chk("t1_dsp_valid", obs_dv, 1);
    chk("t1_dsp_opmode", obs_op, 7'b0110101);
    chk("t1_dsp_id", obs_did, 0);
    cyc_run(LAT + 1, 0);
    chk("t1_res_valid", obs_rv, 1);
    chk("t1_res_id", obs_rid, 0);
    chk("t1_res_p", obs_rp, 48'h123);
    p_fix_en = 0;

    // all four requesting continuously: strict rotation
    do_reset();
    for (int i = 0; i < NREQ; i++) begin op_v[i] = 7'b0000101; alu_v[i] = 4'(i); end
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NREQ; i++) pend[i] = 1;
      cyc_run(1, 0);
      chk("t2_gnt", obs_gnt, 64'(1) << (k % NREQ));
    end
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    cyc_run(LAT + 3, 0);

    // X=01, Y=00 from requester 2 is rejected
    op_v[2] = 7'b0000001; pend[2] = 1;
    cyc_run(1, 0);
    chk("t3_gnt", obs_gnt, 4'b0100);
    cyc_run(1, 0);
    chk("t3_err", obs_err, 1);
    chk("t3_err_id", obs_eid, 2);
    chk("t3_dsp_valid", obs_dv, 0);
    cyc_run(LAT + 3, 0);

    // burst lock by requester 1 blocks others until released
    op_v[2] = 7'b0000101;
    pend[1] = 1; lock_v[1] = 1;
    cyc_run(1, 0);
    chk("t4_lock_gnt", obs_gnt, 4'b0010);
    for (int k = 0; k < 3; k++) begin
      pend[0] = 1; pend[1] = 1; pend[3] = 1;
      cyc_run(1, 0);
      chk("t4_locked_gnt", obs_gnt, 4'b0010);
    end
    pend[1] = 1; lock_v[1] = 0;
    cyc_run(1, 0);
    chk("t4_release_gnt", obs_gnt, 4'b0010);
    cyc_run(1, 0);
    chk("t4_after_gnt", obs_gnt, 4'b1000);
    cyc_run(LAT + 4, 0);

    // reset with operations in flight drops them
    pend[0] = 1; pend[1] = 1; pend[2] = 1;
    cyc_run(3, 0);
    do_reset();
    n_rv = 0;
    for (int k = 0; k < LAT + 2; k++) begin
      cyc_run(1, 0);
      if (obs_rv) n_rv++;
    end
    chk("t5_no_res", n_rv, 0);

`ifdef DSP_ARB_STATS_EN
    do_reset();
    op_v[0] = 7'b0110101; op_v[3] = 7'b0000100;
    for (int k = 0; k < 5; k++) begin pend[0] = 1; cyc_run(1, 0); end
    for (int k = 0; k < 2; k++) begin pend[3] = 1; cyc_run(1, 0); end
    cyc_run(3, 0);
    chk("t6_grant_cnt0", grant_cnt[15:0], 16'd5);
    chk("t6_reject_cnt", reject_cnt, 16'd2);
`endif

    // randomized traffic with occasional resets
    for (int i = 0; i < NREQ; i++) lock_v[i] = 0;
    cyc_run(2000, 1);
    rst_v = 0;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    cyc_run(LAT + 4, 0);
    chk("queue_drained", exp_q.size(), 0);
`ifdef DSP_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) chk("grant_cnt", grant_cnt[i*16 +: 16], 16'(m_gcnt[i]));
    chk("reject_cnt", reject_cnt, 16'(m_rej));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dsp_share_arbiter.md
Name: dsp_share_arbiter

Overview:
- Shares one DSP48E1 slice between NREQ requesters using round-robin arbitration.
- Drives the slice's OPMODE/ALUMODE, one accepted operation per cycle.
- Tracks in-flight operations through the slice pipeline and returns each P result tagged with its requester ID.
- Rejects illegal X/Y multiplexer combinations before they reach the slice.
- Sits between the requester engines and the DSP slice wrapper.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ.
- LAT, 4, cycles from dsp_valid high to the matching P on p_in (1..16).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  NREQ  per-requester operation request.
- lock  in  NREQ  per-requester burst lock; sampled with req.
- opmode_in  in  NREQ*7  per-requester OPMODE; requester i uses bits [7i+6:7i].
- alumode_in  in  NREQ*4  per-requester ALUMODE; requester i uses bits [4i+3:4i].
- gnt  out  NREQ  one-hot acceptance, combinational from req/state.
- err  out  1  one-cycle pulse: illegal OPMODE was rejected.
- err_id  out  IDW  requester whose OPMODE was rejected.
- dsp_opmode  out  7  OPMODE to the slice.
- dsp_alumode  out  4  ALUMODE to the slice.
- dsp_valid  out  1  an operation is issued this cycle.
- dsp_id  out  IDW  owner of the issued operation.
- p_in  in  48  P output of the slice.
- res_valid  out  1  result valid.
- res_id  out  IDW  result owner.
- res_p  out  48  result data.

Behaviour:
- Handshake:
  - A request is accepted in the cycle where req[i] and gnt[i] are both high.
  - At most one gnt bit is high per cycle.
  - The requester holds req, lock, opmode and alumode stable until accepted.
- Round-robin (state IDLE):
  - Grant the first i with req[i]=1, searching from pointer rr upward with wrap-around.
  - After an acceptance by i: rr <= (i+1) mod NREQ.
  - With no requests, rr holds.
- Legality check:
  - X=opmode[1:0], Y=opmode[3:2].
  - Illegal when exactly one of (X==01) and (Y==01) is true; both must select M or neither.
  - An illegal request is still accepted (gnt high).
  - Next cycle: err=1 and err_id=i. No dsp_valid is issued and lock state is unchanged.
- Issue (registered):
  - On legal acceptance, the next cycle has dsp_valid=1, dsp_opmode, dsp_alumode and dsp_id of the accepted request.
  - Otherwise dsp_valid=0; dsp_opmode and dsp_alumode hold their last values.
- States: IDLE and LOCKED.
  - IDLE -> LOCKED: legal acceptance by i with lock[i]=1; owner <= i.
  - In LOCKED only the owner can be granted; all other requests wait. rr is frozen.
  - LOCKED -> IDLE: legal acceptance by the owner with lock=0. That operation issues and rr <= owner+1.
  - An owner idling (req=0) does not release the lock.
- Result tracking:
  - The tag pipeline is LAT stages deep, carrying {valid, id} from dsp_valid/dsp_id.
  - When the tag emerges, register p_in: res_valid=1, res_id=tag, res_p=p_in, one cycle after p_in is valid.
  - End-to-end latency from acceptance to res_valid is LAT+2 cycles.
  - Back-to-back issues produce back-to-back results in issue order.
- Reset values:
  - gnt=0 (combinational, forced during rst), err=0, err_id=0.
  - dsp_opmode=7'b0000000 (X=Y=Z=0), dsp_alumode=0, dsp_valid=0, dsp_id=0.
  - res_valid=0, res_id=0, res_p=0.
  - rr=0, state=IDLE, tag pipeline cleared.
- Reset mid-operation: in-flight operations are dropped; no res_valid for them after reset deasserts.

Optional Feature:
- Macro DSP_ARB_STATS_EN.
- When defined:
  - Add output grant_cnt, NREQ*16 bits.
  - One 16-bit counter per requester, incremented on each legal acceptance.
  - Counters saturate at 16'hFFFF and clear on rst.
  - Add output reject_cnt, 16 bits, saturating, counting err pulses.
- When undefined: neither port exists and no counter logic is built.

Test Plan:
- Reset, then req=4'b0001, opmode_in[6:0]=7'b0110101, alumode=0 -> gnt=0001; next cycle dsp_valid=1, dsp_opmode=0110101, dsp_id=0; p_in=48'h123 at LAT cycles later -> res_valid=1, res_id=0, res_p=48'h123 one cycle after that.
- req=4'b1111 held, all legal, no lock -> grants 0,1,2,3,0,... one per cycle; res_id sequence 0,1,2,3 on consecutive cycles.
- Requester 2, opmode X=01, Y=00 -> gnt[2]=1, next cycle err=1, err_id=2, dsp_valid=0, no result.
- Requester 1 accepted with lock=1, then req=4'b1011 for 3 cycles -> only gnt[1]; after requester 1 is accepted with lock=0, the next grant goes to requester 3.
- Issue 3 operations, assert rst for 1 cycle before the first result -> res_valid stays 0 for LAT+2 cycles after reset; all outputs at reset values.
- With DSP_ARB_STATS_EN: 5 legal grants to requester 0 and 2 illegal from requester 3 -> grant_cnt[15:0]=5, reject_cnt=2.
